// File: rtl/axi_wr_burst_ctrl_pkg.sv
// Shared constants for the AXI write-burst controller.
// FSM state encoding, beat size and AXI page size.
package axi_wr_burst_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_REQ    = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_B = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

    localparam int BEAT_BYTES = 64;
    localparam int PAGE_BYTES = 4096;

endpackage

// File: rtl/axi_wr_burst_ctrl_wr_beat_fifo.sv
// wr_beat_fifo: synchronous FIFO holding {strobe, data} write beats.
// Ports: push/wdata in, pop/rdata out (show-ahead), full, empty, count.
module wr_beat_fifo
    import axi_wr_burst_ctrl_pkg::*;
#(
    parameter int WIDTH = 576,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Extra pointer bit makes full/empty exact with no slack.
    assign count = wptr - rptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// axi_wr_burst_ctrl: buffers decompressor beats, issues 4KB-safe AXI write bursts.
// Ports: start/des_addr/len -> done/idle; in_* beat stream; dma_wr_* burst master.
// Optional `WR_PERF_CNT_EN adds perf_bursts/perf_stall saturating counters.
module axi_wr_burst_ctrl
    import axi_wr_burst_ctrl_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int MAX_BURST          = 64,
    parameter int FIFO_DEPTH         = 128
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     des_addr,
    input  logic [31:0]                       decompression_length,
    output logic                              done,
    output logic                              idle,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     in_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   in_strobe,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              dma_wr_req,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     dma_wr_addr,
    output logic [7:0]                        dma_wr_len,
    input  logic                              dma_wr_req_ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     dma_wr_data,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   dma_wr_strobe,
    output logic                              dma_wr_wvalid,
    output logic                              dma_wr_data_last,
    input  logic                              dma_wr_ready,
    output logic                              dma_wr_bready,
    input  logic                              dma_wr_done
`ifdef WR_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_bursts,
    output logic [31:0]                       perf_stall
`endif
);

    localparam int DW         = C_M_AXI_DATA_WIDTH;
    localparam int SW         = DW / 8;
    localparam int AW         = C_M_AXI_ADDR_WIDTH;
    localparam int SHIFT      = $clog2(SW);
    localparam int PAGE_BEATS = PAGE_BYTES / SW;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic [STATE_W-1:0] state;
    logic [AW-1:0]      addr;
    logic [26:0]        total;
    logic [26:0]        left;
    logic [26:0]        accepted;
    logic [8:0]         burst;
    logic [7:0]         beat_cnt;
    logic               done_r;

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CW-1:0]      fifo_count;
    logic [SW+DW-1:0]   fifo_head;
    logic [32:0]        len_up;
    logic [26:0]        total_next;
    logic [AW-1:0]      step_addr;
    logic [26:0]        step_left;
    logic               start_ok;

    // Beats left before the next 4KB page boundary, capped by MAX_BURST.
    function automatic logic [8:0] size_burst(
        input logic [11-SHIFT:0] pg,
        input logic [26:0]       l
    );
        logic [26:0] room;
        logic [26:0] n;
        room = 27'(PAGE_BEATS) - 27'(pg);
        n    = l;
        if (room < n)
            n = room;
        if (27'(MAX_BURST) < n)
            n = 27'(MAX_BURST);
        return n[8:0];
    endfunction

    assign len_up     = {1'b0, decompression_length} + 33'(SW - 1);
    assign total_next = 27'(len_up >> SHIFT);
    assign step_addr  = addr + (AW'(burst) << SHIFT);
    assign step_left  = left - 27'(burst);
    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);

    assign in_ready = (state != ST_IDLE) && !full && (accepted < total);
    assign push     = in_valid && in_ready;
    assign pop      = dma_wr_wvalid && dma_wr_ready;

    // Request waits until the whole burst is buffered so W never starves.
    assign dma_wr_req       = (state == ST_REQ) &&
                              (32'(fifo_count) >= 32'(burst));
    assign dma_wr_addr      = addr;
    assign dma_wr_len       = 8'(burst - 9'd1);
    assign dma_wr_wvalid    = (state == ST_DATA) && !empty;
    assign dma_wr_data_last = dma_wr_wvalid && (beat_cnt == dma_wr_len);
    assign dma_wr_bready    = (state == ST_WAIT_B);
    assign dma_wr_data      = fifo_head[DW-1:0];
    assign dma_wr_strobe    = fifo_head[SW+DW-1:DW];
    assign idle             = (state == ST_IDLE) || (state == ST_DONE);
    assign done             = done_r;

    wr_beat_fifo #(
        .WIDTH (SW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({in_strobe, in_data}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr     <= '0;
            total    <= '0;
            left     <= '0;
            accepted <= '0;
            burst    <= '0;
            beat_cnt <= '0;
            done_r   <= 1'b0;
        end else begin
            if (push)
                accepted <= accepted + 27'd1;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        addr     <= des_addr;
                        total    <= total_next;
                        left     <= total_next;
                        accepted <= '0;
                        burst    <= size_burst(des_addr[11:SHIFT],
                                               total_next);
                        done_r   <= (total_next == '0);
                        state    <= (total_next == '0) ? ST_DONE : ST_REQ;
                    end else if (state == ST_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dma_wr_req && dma_wr_req_ack) begin
                        beat_cnt <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (dma_wr_data_last)
                            state <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (dma_wr_done) begin
                        addr  <= step_addr;
                        left  <= step_left;
                        burst <= size_burst(step_addr[11:SHIFT], step_left);
                        if (step_left == '0) begin
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WR_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_bursts <= '0;
            perf_stall  <= '0;
        end else if (start_ok) begin
            perf_bursts <= '0;
            perf_stall  <= '0;
        end else begin
            if (dma_wr_bready && dma_wr_done && perf_bursts != '1)
                perf_bursts <= perf_bursts + 32'd1;
            if (dma_wr_wvalid && !dma_wr_ready && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
